// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int FRAME_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and registered read data.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (do_rd) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and launches them one at a time into the UART Tx.
// state     | meaning
// IDLE      | waiting for a queued byte and an idle Tx
// LAUNCH    | byte just popped onto tx_data, enable pulse being issued
// WAIT_BUSY | waiting for Tx to raise busy, bounded by BUSY_TIMEOUT
// WAIT_DONE | frame on the line, waiting for busy to drop
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 15,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       tx_enable,
  output logic [DATA_WIDTH-1:0]      tx_data,
  input  logic                       tx_busy,
  output logic [ADDR_WIDTH:0]        fifo_count,
  output logic [FRAME_CNT_WIDTH-1:0] frames_sent,
  output logic                       launch_timeout
);

  localparam int TO_WIDTH = $clog2(BUSY_TIMEOUT + 1);

  feeder_state_t              state;
  feeder_state_t              state_next;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       launch_now;
  logic                       timeout_now;
  logic                       frame_done;
  logic                       tx_enable_q;
  logic [TO_WIDTH-1:0]        to_cnt;
  logic [FRAME_CNT_WIDTH-1:0] frames_cnt;

  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;
  assign pop     = (state == IDLE) && !fifo_empty && !tx_busy;

  // The FIFO's registered read port is the held tx_data.
  uart_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_data(s_data),
    .rd_en  (pop),
    .rd_data(tx_data),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (to_cnt == TO_WIDTH'(1)) begin
          state_next = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    launch_now  = (state == LAUNCH);
    timeout_now = (state == WAIT_BUSY) && !tx_busy && (to_cnt == TO_WIDTH'(1));
    frame_done  = (state == WAIT_DONE) && !tx_busy;
  end

  // Timeout is a down-counter loaded on launch; expiry is the terminal count of 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_enable_q    <= 1'b0;
      launch_timeout <= 1'b0;
      to_cnt         <= '0;
      frames_cnt     <= '0;
    end else begin
      tx_enable_q    <= launch_now;
      launch_timeout <= timeout_now;
      if (launch_now) begin
        to_cnt <= TO_WIDTH'(BUSY_TIMEOUT);
      end else if ((state == WAIT_BUSY) && !tx_busy && (to_cnt != '0)) begin
        to_cnt <= to_cnt - TO_WIDTH'(1);
      end
      if (frame_done) begin
        frames_cnt <= frames_cnt + FRAME_CNT_WIDTH'(1);
      end
    end
  end

  assign tx_enable   = tx_enable_q && !reset;
  assign frames_sent = frames_cnt;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder against a queue-based behavioural model.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int TO    = 15;

  localparam int M_FREE   = 0;
  localparam int M_LAUNCH = 1;
  localparam int M_WAIT   = 2;
  localparam int M_FRAME  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [4:0]  fifo_count;
  logic [15:0] frames_sent;
  logic        launch_timeout;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DATA_WIDTH  (8),
    .DEPTH       (DEPTH),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .tx_enable     (tx_enable),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count),
    .frames_sent   (frames_sent),
    .launch_timeout(launch_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: raises busy one cycle after it sees enable, for busy_len cycles.
  int   busy_len   = 4;
  int   busy_left  = 0;
  logic en_seen    = 1'b0;
  logic force_busy = 1'b0;
  logic tx_no_busy = 1'b0;

  always @(posedge clk) begin
    #2;
    if (reset) begin
      busy_left = 0;
      en_seen   = 1'b0;
    end else begin
      if (en_seen && !tx_no_busy) busy_left = busy_len;
      en_seen = tx_enable;
    end
    tx_busy = force_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
  end

  // Behavioural reference: a byte queue plus the launch/frame lifecycle.
  logic [7:0]  m_q[$];
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_frames = 16'h0000;
  logic        m_en = 1'b0;
  logic        m_to = 1'b0;
  int          m_phase = M_FREE;
  int          m_wait = 0;
  int          m_sz;
  int          preload_seq = 0;
  int          m_seen_preload = 0;

  always @(posedge clk) begin
    if (preload_seq != m_seen_preload) begin
      m_frames       = 16'hFFFF;
      m_seen_preload = preload_seq;
    end
    m_en = 1'b0;
    m_to = 1'b0;
    if (reset) begin
      m_q.delete();
      m_frames = 16'h0000;
      m_data   = 8'h00;
      m_phase  = M_FREE;
      m_wait   = 0;
    end else begin
      m_sz = m_q.size();
      case (m_phase)
        M_FREE: begin
          if (m_sz > 0 && !tx_busy) begin
            m_data  = m_q.pop_front();
            m_phase = M_LAUNCH;
          end
        end
        M_LAUNCH: begin
          m_en    = 1'b1;
          m_wait  = 0;
          m_phase = M_WAIT;
        end
        M_WAIT: begin
          if (tx_busy) begin
            m_phase = M_FRAME;
          end else begin
            m_wait++;
            if (m_wait == TO) begin
              m_to    = 1'b1;
              m_phase = M_FREE;
            end
          end
        end
        default: begin
          if (!tx_busy) begin
            m_frames = m_frames + 16'd1;
            m_phase  = M_FREE;
          end
        end
      endcase
      if (s_valid && m_sz < DEPTH) m_q.push_back(s_data);
    end
  end

  logic [7:0] launched[$];
  logic [7:0] last_launch = 8'h00;

  always @(negedge clk) begin
    check("fifo_count", fifo_count, m_q.size());
    check("s_ready", s_ready, (m_q.size() < DEPTH));
    check("tx_data", tx_data, m_data);
    check("tx_enable", tx_enable, (m_en && !reset));
    check("launch_timeout", launch_timeout, m_to);
    check("frames_sent", frames_sent, m_frames);
    check("enable_while_busy", (tx_enable && tx_busy), 0);
    if (tx_enable) begin
      launched.push_back(tx_data);
      last_launch = tx_data;
    end
    if (tx_busy && !reset) check("tx_data_hold", tx_data, last_launch);
  end

  task automatic wait_frames(input logic [15:0] target, input int limit, input string name);
    int k = 0;
    while (frames_sent != target && k < limit) begin
      tick();
      k++;
    end
    check(name, frames_sent, target);
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  int         base;
  int         k;
  int         en_cnt;
  int         sent;
  int         cyc;
  logic [7:0] exp_q[$];
  logic [7:0] rb;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_count", fifo_count, 0);
    check("reset_ready", s_ready, 1);
    check("reset_frames", frames_sent, 0);
    check("reset_data", tx_data, 0);

    // Single byte latency and a long frame
    busy_len = 110;
    push_byte(8'hA5);
    check("lat_en_w", tx_enable, 0);
    tick();
    check("lat_data", tx_data, 8'hA5);
    check("lat_en_w1", tx_enable, 0);
    tick();
    check("lat_en_w2", tx_enable, 1);
    tick();
    check("en_pulse_end", tx_enable, 0);
    wait_frames(16'd1, 300, "frame1_done");
    check("frame1_count", fifo_count, 0);

    // Fill to full while the Tx is held busy, then drain
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(i[7:0]);
    check("full_count", fifo_count, 16);
    check("full_ready", s_ready, 0);
    push_byte(8'hFF);
    check("no_17th", fifo_count, 16);
    base = launched.size();
    busy_len = 3;
    force_busy = 1'b0;
    wait_frames(16'd17, 600, "burst_done");
    for (int i = 0; i < 16; i++) check("burst_order", launched[base + i], i);

    // Push and pop on the same edge at occupancy 5
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    check("pp_before", fifo_count, 5);
    force_busy = 1'b0;
    push_byte(8'h55);
    check("pp_after", fifo_count, 5);
    wait_frames(16'd23, 400, "pp_done");

    // Random streaming of 40 bytes through the wrapping FIFO
    base = launched.size();
    exp_q.delete();
    sent = 0;
    cyc = 0;
    while (sent < 40 && cyc < 3000) begin
      busy_len = $urandom_range(1, 8);
      if ($urandom_range(0, 3) != 0 && s_ready) begin
        rb = 8'($urandom);
        exp_q.push_back(rb);
        s_valid = 1'b1;
        s_data  = rb;
        sent++;
      end else if (!s_ready) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    wait_frames(16'd63, 3000, "stream_done");
    for (int i = 0; i < 40; i++) check("stream_order", launched[base + i], exp_q[i]);

    // Tx never answers: launch abandoned after BUSY_TIMEOUT cycles
    tx_no_busy = 1'b1;
    base = launched.size();
    push_byte(8'h3C);
    k = 0;
    while (!tx_enable && k < 20) begin
      tick();
      k++;
    end
    check("to_launch_seen", tx_enable, 1);
    k = 0;
    while (!launch_timeout && k < 40) begin
      tick();
      k++;
    end
    check("to_delay", k, 15);
    check("to_frames", frames_sent, 63);
    tx_no_busy = 1'b0;
    busy_len = 5;
    push_byte(8'h77);
    wait_frames(16'd64, 200, "after_to_done");
    check("to_byte", launched[base], 8'h3C);
    check("after_to_byte", launched[base + 1], 8'h77);

    // Frame counter wrap from a preloaded 0xFFFF
    @(negedge clk);
    #1;
    force dut.frames_cnt = 16'hFFFF;
    #1;
    release dut.frames_cnt;
    preload_seq++;
    tick();
    push_byte(8'h99);
    wait_frames(16'd0, 200, "frames_wrap");

    // Reset while a frame is on the line with three bytes queued
    busy_len = 60;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    k = 0;
    while (!tx_busy && k < 20) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("pre_reset_count", fifo_count, 3);
    reset = 1'b1;
    tick();
    check("rst_count", fifo_count, 0);
    check("rst_enable", tx_enable, 0);
    check("rst_data", tx_data, 0);
    check("rst_frames", frames_sent, 0);
    reset = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_enable) en_cnt++;
    end
    check("no_relaunch", en_cnt, 0);
    base = launched.size();
    busy_len = 4;
    push_byte(8'hE1);
    wait_frames(16'd1, 200, "post_reset_frame");
    check("post_reset_byte", launched[base], 8'hE1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
